// File: rtl/exp_series_stage.sv
// exp_series_stage: e^A by truncated Taylor series on one shared multiplier, scaled by E = e^a.
// Ports:
//   CLK, rst (async active-low)       clock and reset
//   start                              capture request, honoured only in IDLE
//   FLOAT32_IN / A_IN / E_IN           e^b word, A = x - a (Q3.23), E = e^a (Q3.23)
//   ready                              high while IDLE
//   done                               one-cycle pulse when outputs update
//   FLOAT32_OUT / PRODUCT              captured e^b word, e^A * E (Q3.23, saturating)
//   d_state                            current state encoding
module exp_series_stage #(
  parameter int TERMS = 7
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] FLOAT32_IN,
  input  logic [25:0] A_IN,
  input  logic [25:0] E_IN,
  output logic        ready,
  output logic        done,
  output logic [31:0] FLOAT32_OUT,
  output logic [25:0] PRODUCT,
  output logic [2:0]  d_state
);
  typedef enum logic [2:0] {IDLE = 3'd0, MUL_A = 3'd1, MUL_R = 3'd2, FINAL = 3'd3, DONE = 3'd4} state_t;
  state_t state, state_nx;
  logic [25:0] a_r, e_r, term, sum, recip, op_x, op_y, mul_q, sum_nx;
  logic [31:0] f_r;
  logic [2:0]  k;
  logic [51:0] prod;
  logic [26:0] add;
  always_comb begin
    recip = 26'h0;
    case (k)
      3'd1: recip = 26'h800000;
      3'd2: recip = 26'h400000;
      3'd3: recip = 26'h2AAAAA;
      3'd4: recip = 26'h200000;
      3'd5: recip = 26'h199999;
      3'd6: recip = 26'h155555;
      3'd7: recip = 26'h124924;
      default: recip = 26'h0;
    endcase
  end
  // Single multiplier: operands steered by state.
  assign op_x   = state == FINAL ? sum : term;
  assign op_y   = state == MUL_A ? a_r : state == FINAL ? e_r : recip;
  assign prod   = {26'b0, op_x} * {26'b0, op_y};
  assign mul_q  = |prod[51:49] ? 26'h3FFFFFF : prod[48:23];
  // The running sum accumulates the freshly scaled term, not the stored one.
  assign add    = {1'b0, sum} + {1'b0, mul_q};
  assign sum_nx = add[26] ? 26'h3FFFFFF : add[25:0];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? MUL_A : IDLE;
      MUL_A:   state_nx = MUL_R;
      MUL_R:   state_nx = k == 3'(TERMS) ? FINAL : MUL_A;
      FINAL:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      a_r         <= '0;
      e_r         <= '0;
      f_r         <= '0;
      term        <= '0;
      sum         <= '0;
      k           <= '0;
      PRODUCT     <= '0;
      FLOAT32_OUT <= '0;
    end else begin
      state <= state_nx;
      done  <= state == FINAL;
      case (state)
        IDLE: if (start) begin
          a_r  <= A_IN;
          e_r  <= E_IN;
          f_r  <= FLOAT32_IN;
          term <= 26'h800000;
          sum  <= 26'h800000;
          k    <= 3'd1;
        end
        MUL_A: term <= mul_q;
        MUL_R: begin
          term <= mul_q;
          sum  <= sum_nx;
          k    <= k + 3'd1;
        end
        FINAL: begin
          PRODUCT     <= mul_q;
          FLOAT32_OUT <= f_r;
        end
        default: ;
      endcase
    end
  end
  assign ready   = state == IDLE;
  assign d_state = state;
endmodule

// File: tb/tb_exp_series_stage.sv
// tb_exp_series_stage: directed and random checks of exp_series_stage for TERMS=7 and TERMS=4.
module tb_exp_series_stage;
  logic        CLK, rst, start7, start4;
  logic [31:0] f_in;
  logic [25:0] a_in, e_in;
  logic        rdy7, done7, rdy4, done4;
  logic [31:0] fo7, fo4;
  logic [25:0] p7, p4;
  logic [2:0]  ds7, ds4;
  int n_cmp = 0, n_err = 0;

  exp_series_stage #(.TERMS(7)) u7 (.CLK(CLK), .rst(rst), .start(start7), .FLOAT32_IN(f_in), .A_IN(a_in), .E_IN(e_in),
    .ready(rdy7), .done(done7), .FLOAT32_OUT(fo7), .PRODUCT(p7), .d_state(ds7));
  exp_series_stage #(.TERMS(4)) u4 (.CLK(CLK), .rst(rst), .start(start4), .FLOAT32_IN(f_in), .A_IN(a_in), .E_IN(e_in),
    .ready(rdy4), .done(done4), .FLOAT32_OUT(fo4), .PRODUCT(p4), .d_state(ds4));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned mulq(input longint unsigned a, input longint unsigned b);
    longint unsigned p = a * b;
    return (p >> 49) != 0 ? 64'h3FFFFFF : (p >> 23);
  endfunction

  // e^A * E from the series definition: term_k = term_{k-1} * A / k, sum of 1 + terms.
  function automatic logic [25:0] model(input int t, input logic [25:0] a, input logic [25:0] e);
    longint unsigned term = 64'd1 << 23, sum = 64'd1 << 23;
    for (int k = 1; k <= t; k++) begin
      term = mulq(term, a);
      term = mulq(term, (64'd1 << 23) / longint'(k));
      sum += term;
      if (sum > 64'h3FFFFFF) sum = 64'h3FFFFFF;
    end
    return 26'(mulq(sum, e));
  endfunction

  function automatic logic rdy_of(input int t);  return t == 7 ? rdy7 : rdy4;  endfunction
  function automatic logic done_of(input int t); return t == 7 ? done7 : done4; endfunction
  function automatic logic [25:0] p_of(input int t);  return t == 7 ? p7 : p4;  endfunction
  function automatic logic [31:0] fo_of(input int t); return t == 7 ? fo7 : fo4; endfunction
  function automatic logic [2:0] ds_of(input int t);  return t == 7 ? ds7 : ds4; endfunction

  task automatic set_start(input int t, input logic v);
    if (t == 7) start7 = v; else start4 = v;
  endtask

  task automatic run(input int t, input logic [25:0] a, input logic [25:0] e, input logic [31:0] f);
    int lat;
    logic [25:0] exp_p;
    exp_p = model(t, a, e);
    @(negedge CLK);
    a_in = a; e_in = e; f_in = f;
    set_start(t, 1'b1);
    chk("ready_before", 32'(rdy_of(t)), 32'd1);
    @(posedge CLK); #1;
    set_start(t, 1'b0);
    a_in = 26'($urandom); e_in = 26'($urandom); f_in = $urandom;
    chk("ready_fall", 32'(rdy_of(t)), 32'd0);
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!done_of(t) && lat < 60);
    chk("latency", 32'(lat), 32'(2 * t + 1));
    chk("product", 32'(p_of(t)), 32'(exp_p));
    chk("float_out", fo_of(t), f);
    chk("d_state_done", 32'(ds_of(t)), 32'd4);
    @(posedge CLK); #1;
    chk("idle_after", {30'b0, rdy_of(t), done_of(t)}, 32'b10);
  endtask

  initial begin
    logic [25:0] va1, ve1, va2, ve2;
    logic [31:0] vf1, vf2;
    int pulses;
    rst = 1'b1; start7 = 1'b0; start4 = 1'b0;
    a_in = '0; e_in = '0; f_in = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_p7", 32'(p7), 32'd0);
    chk("rst_fo7", fo7, 32'd0);
    chk("rst_rdy_done7", {30'b0, rdy7, done7}, 32'b10);
    chk("rst_ds7", 32'(ds7), 32'd0);
    chk("rst_p4", 32'(p4), 32'd0);
    chk("rst_rdy_done4", {30'b0, rdy4, done4}, 32'b10);
    @(negedge CLK); rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk("idle_no_done", {30'b0, done7, done4}, 32'd0);
    end

    run(7, 26'h0, 26'h800000, 32'h3F800000);
    chk("identity", 32'(p7), 32'h800000);
    run(4, 26'h800000, 26'h800000, 32'h40000000);
    chk("series_t4", 32'(p4), 32'h15AAAAA);
    run(4, 26'h800000, 26'h3FFFFFF, 32'h12345678);
    chk("sat_e_t4", 32'(p4), 32'h3FFFFFF);
    run(7, 26'h3FFFFFF, 26'h800000, 32'h87654321);
    chk("sat_a_t7", 32'(p7), 32'h3FFFFFF);

    for (int i = 0; i < 8; i++)
      run(i % 2 ? 4 : 7, 26'($urandom_range(0, 32'h1FFFFFF)), 26'($urandom_range(0, 32'h17FFFFF)), $urandom);

    va1 = 26'($urandom_range(0, 32'hFFFFFF)); ve1 = 26'($urandom_range(0, 32'hFFFFFF)); vf1 = $urandom;
    va2 = 26'($urandom_range(0, 32'hFFFFFF)); ve2 = 26'($urandom_range(0, 32'hFFFFFF)); vf2 = $urandom;
    @(negedge CLK);
    a_in = va1; e_in = ve1; f_in = vf1; start7 = 1'b1;
    @(posedge CLK); #1;
    a_in = va2; e_in = ve2; f_in = vf2;
    pulses = 0;
    for (int c = 1; c <= 34; c++) begin
      @(posedge CLK); #1;
      if (c == 20) start7 = 1'b0;
      if (c == 16) chk("busy_idle", 32'(rdy7), 32'd1);
      if (c == 17) chk("busy_recapture", 32'(rdy7), 32'd0);
      if (done7) begin
        pulses++;
        if (pulses == 1) begin
          chk("busy_lat1", 32'(c), 32'd15);
          chk("busy_p1", 32'(p7), 32'(model(7, va1, ve1)));
          chk("busy_f1", fo7, vf1);
        end else begin
          chk("busy_lat2", 32'(c), 32'd32);
          chk("busy_p2", 32'(p7), 32'(model(7, va2, ve2)));
          chk("busy_f2", fo7, vf2);
        end
      end
    end
    chk("busy_pulses", 32'(pulses), 32'd2);

    @(negedge CLK);
    a_in = 26'h800000; e_in = 26'h800000; f_in = 32'hCAFEF00D; start7 = 1'b1;
    @(posedge CLK); #1;
    start7 = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("abort_in_mul_r", 32'(ds7), 32'd2);
    rst = 1'b0;
    #1;
    chk("abort_p7", 32'(p7), 32'd0);
    chk("abort_fo7", fo7, 32'd0);
    chk("abort_rdy_done7", {30'b0, rdy7, done7}, 32'b10);
    chk("abort_ds7", 32'(ds7), 32'd0);
    chk("abort_p4", 32'(p4), 32'd0);
    @(negedge CLK); rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (done7) pulses++;
    end
    chk("abort_no_stale_done", 32'(pulses), 32'd0);
    run(7, 26'h0, 26'h400000, 32'h3F000000);
    chk("restart", 32'(p7), 32'h400000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
